// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and muldiv FSM encoding.
// Helper functions give operand signedness per M-extension funct3.
package riscv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StSign = 2'd2,
    StDone = 2'd3
  } muldiv_state_e;

  function automatic logic rs1_is_signed(input logic [2:0] op);
    return (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] op);
    return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Applies result signs and selects the architectural result for the SIGN state.
module muldiv_sign_fix
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        op_i,
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN-1:0]   quo_i,
  input  logic [XLEN-1:0]   rem_i,
  input  logic              neg_prod_i,
  input  logic              neg_quo_i,
  input  logic              neg_rem_i,
  input  logic              special_i,
  input  logic [XLEN-1:0]   spec_val_i,
  output logic [XLEN-1:0]   result_o
);

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_prod_i ? -prod_i : prod_i;
    quo_fix  = neg_quo_i ? -quo_i : quo_i;
    rem_fix  = neg_rem_i ? -rem_i : rem_i;
    result_o = '0;
    if (special_i) begin
      result_o = spec_val_i;
    end else begin
      unique case (op_i)
        F3_MUL:                        result_o = prod_fix[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU:  result_o = prod_fix[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:               result_o = quo_fix;
        F3_REM, F3_REMU:               result_o = rem_fix;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with a final sign-fix cycle.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;    // multiplicand, or dividend/quotient shift register
  logic [XLEN-1:0]   b_q, b_d;    // multiplier shift register, or divisor
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic              q_bit;
  logic [XLEN-1:0]   fix_result;

  always_comb begin
    s1       = rs1_is_signed(op_i) & rs1_data_i[XLEN-1];
    s2       = rs2_is_signed(op_i) & rs2_data_i[XLEN-1];
    mag1     = s1 ? -rs1_data_i : rs1_data_i;
    mag2     = s2 ? -rs2_data_i : rs2_data_i;
    div_zero = op_i[2] && (rs2_data_i == '0);
    div_ovf  = ((op_i == F3_DIV) || (op_i == F3_REM)) &&
               (rs1_data_i == IntMin) && (rs2_data_i == '1);
    // Restoring step: bring in next dividend bit, keep the difference if it fits.
    rem_shift = {acc_q[XLEN-1:0], a_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    q_bit     = ~rem_diff[XLEN];
  end

  muldiv_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .op_i       (op_q),
    .prod_i     (acc_q),
    .quo_i      (a_q),
    .rem_i      (acc_q[XLEN-1:0]),
    .neg_prod_i (sa_q ^ sb_q),
    .neg_quo_i  (sa_q ^ sb_q),
    .neg_rem_i  (sa_q),
    .special_i  (special_q),
    .spec_val_i (spec_val_q),
    .result_o   (fix_result)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    special_d  = special_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          op_d       = op_i;
          a_d        = mag1;
          b_d        = mag2;
          sa_d       = s1;
          sb_d       = s2;
          acc_d      = '0;
          cnt_d      = '0;
          special_d  = div_zero | div_ovf;
          // op_i[1] separates REM/REMU from DIV/DIVU among divide ops.
          if (div_zero) begin
            spec_val_d = op_i[1] ? rs1_data_i : '1;
          end else begin
            spec_val_d = op_i[1] ? '0 : IntMin;
          end
          state_d    = (div_zero | div_ovf) ? StSign : StCalc;
        end
      end
      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          if (op_q[2]) begin
            acc_d = {{(XLEN-1){1'b0}}, (q_bit ? rem_diff : rem_shift)};
            a_d   = {a_q[XLEN-2:0], q_bit};
          end else begin
            acc_d = {acc_q[2*XLEN-2:0], 1'b0} +
                    (b_q[XLEN-1] ? {{XLEN{1'b0}}, a_q} : {(2*XLEN){1'b0}});
            b_d   = {b_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = StSign;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StSign: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          result_d = fix_result;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      special_q  <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      special_q  <= special_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    busy_o   = (state_q != StIdle);
    done_o   = (state_q == StDone);
    result_o = result_q;
  end

endmodule
